// File: rtl/ccu_axil_master_pkg.sv
// Shared definitions for the CCU AXI-Lite command master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: command op codes, response status codes, FSM state encoding,
// the fixed AXI protection value and a saturating 16-bit increment helper.
package ccu_axil_master_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_RSVD = 2'b11   // behaves as a plain read
  } op_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_BUSERR = 2'b01,
    ST_POLLX  = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_GAP     = 3'd5,
    S_RSP     = 3'd6
  } state_e;

  localparam logic [2:0] AXI_PROT = 3'b000;

  // Read counter sticks at all-ones instead of wrapping (unlimited polls).
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ccu_axil_master.sv
// AXI-Lite initiator turning single register commands (write/read/poll) into bus transactions.
// Latency: zero-wait slave write accept T, AW/W at T+1, rsp_valid the cycle after B; one transaction outstanding.
// Backpressure: cmd_ready low while busy; rsp_valid holds stable data until rsp_ready; AXI valids held until handshake.
// Ports: clk/rst (sync, active-high); cmd_* command in (valid/ready); rsp_* result out (valid/ready);
// m_axil_* AXI-Lite master AW, W, B, AR and R channels (32-bit data, ADDR_WIDTH byte address).
module ccu_axil_master
  import ccu_axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int POLL_LIMIT = 1024,
  parameter int POLL_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  input  logic [31:0]           cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_status,
  output logic [15:0]           rsp_polls,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [31:0]           m_axil_wdata,
  output logic [3:0]            m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [31:0]           m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  state_e                state;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           mask_q;
  logic                  aw_done;
  logic                  w_done;
  logic [15:0]           poll_cnt;
  logic [15:0]           gap_cnt;

  logic aw_hs, w_hs, poll_match, poll_exhausted;

  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid && m_axil_wready;

  assign poll_match     = ((m_axil_rdata & mask_q) == (wdata_q & mask_q));
  assign poll_exhausted = (POLL_LIMIT != 0) && ({16'd0, poll_cnt} == 32'(POLL_LIMIT));

  // The same latched address serves both AW and AR; only one is ever valid.
  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = AXI_PROT;
  assign m_axil_arprot = AXI_PROT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= OP_WR;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      mask_q         <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      poll_cnt       <= '0;
      gap_cnt        <= '0;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_status     <= '0;
      rsp_polls      <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= op_e'(cmd_op);
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            mask_q    <= cmd_mask;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            poll_cnt  <= '0;
            if (op_e'(cmd_op) == OP_WR) begin
              state          <= S_WR;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              m_axil_bready  <= 1'b1;
            end else begin
              state          <= S_RD_ADDR;
              m_axil_arvalid <= 1'b1;
            end
          end
        end

        S_WR: begin
          if (aw_hs) begin
            m_axil_awvalid <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_hs) begin
            m_axil_wvalid <= 1'b0;
            w_done        <= 1'b1;
          end
          // A B arriving together with the final AW/W handshake is consumed here.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            if (m_axil_bvalid) begin
              m_axil_bready <= 1'b0;
              rsp_valid     <= 1'b1;
              rsp_rdata     <= '0;
              rsp_polls     <= '0;
              rsp_status    <= (m_axil_bresp != 2'b00) ? ST_BUSERR : ST_OK;
              state         <= S_RSP;
            end else begin
              state <= S_WR_RESP;
            end
          end
        end

        S_WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_polls     <= '0;
            rsp_status    <= (m_axil_bresp != 2'b00) ? ST_BUSERR : ST_OK;
            state         <= S_RSP;
          end
        end

        S_RD_ADDR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            poll_cnt       <= sat_inc16(poll_cnt);
            state          <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rsp_rdata     <= m_axil_rdata;
            rsp_polls     <= poll_cnt;
            // Bus error ends any command; a match wins over exhaustion on the last read.
            if (m_axil_rresp != 2'b00) begin
              rsp_status <= ST_BUSERR;
              rsp_valid  <= 1'b1;
              state      <= S_RSP;
            end else if (op_q != OP_POLL || poll_match) begin
              rsp_status <= ST_OK;
              rsp_valid  <= 1'b1;
              state      <= S_RSP;
            end else if (poll_exhausted) begin
              rsp_status <= ST_POLLX;
              rsp_valid  <= 1'b1;
              state      <= S_RSP;
            end else if (POLL_GAP == 0) begin
              m_axil_arvalid <= 1'b1;
              state          <= S_RD_ADDR;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == 16'(POLL_GAP - 1)) begin
            m_axil_arvalid <= 1'b1;
            state          <= S_RD_ADDR;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_axil_master.sv
// Directed self-checking bench for ccu_axil_master with a small AXI-Lite register slave model.
// Latency: n/a (testbench).
// Backpressure: slave model can stall AW/W by a programmable count and block AR indefinitely.
module tb_ccu_axil_master;

  localparam int AW = 8;
  localparam int PL = 6;
  localparam int PG = 4;
  localparam logic [7:0] POLL_ADDR = 8'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic [31:0]   cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_status;
  logic [15:0]   rsp_polls;

  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [31:0]   m_axil_wdata;
  logic [3:0]    m_axil_wstrb;
  logic [1:0]    m_axil_bresp = 2'b00;
  logic          m_axil_bvalid = 1'b0;
  logic          m_axil_bready;
  logic          m_axil_arvalid, m_axil_arready;
  logic [31:0]   m_axil_rdata = '0;
  logic [1:0]    m_axil_rresp = 2'b00;
  logic          m_axil_rvalid = 1'b0;
  logic          m_axil_rready;

  ccu_axil_master #(.ADDR_WIDTH(AW), .POLL_LIMIT(PL), .POLL_GAP(PG)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .rsp_polls(rsp_polls),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  // ---------------- slave model ----------------
  int         aw_dly = 0, w_dly = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic       ar_block = 1'b0;
  int         poll_zeros = 0, poll_base = 0;

  int            cyc = 0;
  int            aw_cnt = 0, w_cnt = 0;
  logic          got_aw = 1'b0, got_w = 1'b0;
  logic [AW-1:0] aw_addr_l = '0;
  logic [31:0]   w_data_l = '0;
  logic [3:0]    w_strb_l = '0;
  logic [31:0]   mem [0:63] = '{default: 32'd0};
  int            ar_total = 0, b_total = 0, aw_hi = 0, w_hi = 0;
  int            ar_cyc [0:255] = '{default: 0};
  logic          overlap_err = 1'b0;

  logic          aw_hs, w_hs, ar_hs;
  logic [AW-1:0] wa;
  logic [31:0]   wd, rd_val;
  logic [3:0]    ws;
  int            pidx;

  assign m_axil_awready = m_axil_awvalid && (aw_cnt >= aw_dly);
  assign m_axil_wready  = m_axil_wvalid && (w_cnt >= w_dly);
  assign m_axil_arready = m_axil_arvalid && !ar_block;
  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid && m_axil_wready;
  assign ar_hs = m_axil_arvalid && m_axil_arready;
  assign wa = aw_hs ? m_axil_awaddr : aw_addr_l;
  assign wd = w_hs ? m_axil_wdata : w_data_l;
  assign ws = w_hs ? m_axil_wstrb : w_strb_l;
  // Poll register: distinct values with bit0 clear for the first poll_zeros reads, then 1.
  assign pidx   = ar_total - poll_base;
  assign rd_val = (m_axil_araddr == POLL_ADDR) ?
                  ((pidx < poll_zeros) ? 32'((pidx + 1) * 256) : 32'd1) :
                  mem[m_axil_araddr[7:2]];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    aw_cnt <= (m_axil_awvalid && !m_axil_awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (m_axil_wvalid && !m_axil_wready) ? w_cnt + 1 : 0;
    if (m_axil_awvalid) aw_hi <= aw_hi + 1;
    if (m_axil_wvalid) w_hi <= w_hi + 1;
    if ((m_axil_awvalid || m_axil_wvalid) && m_axil_arvalid) overlap_err <= 1'b1;
    if (aw_hs) begin got_aw <= 1'b1; aw_addr_l <= m_axil_awaddr; end
    if (w_hs) begin got_w <= 1'b1; w_data_l <= m_axil_wdata; w_strb_l <= m_axil_wstrb; end
    if (m_axil_bvalid && m_axil_bready) begin
      m_axil_bvalid <= 1'b0;
      b_total       <= b_total + 1;
    end
    if ((got_aw || aw_hs) && (got_w || w_hs)) begin
      for (int i = 0; i < 4; i++)
        if (ws[i]) mem[wa[7:2]][8*i +: 8] <= wd[8*i +: 8];
      got_aw        <= 1'b0;
      got_w         <= 1'b0;
      m_axil_bvalid <= 1'b1;
      m_axil_bresp  <= bresp_cfg;
    end
    if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
    if (ar_hs) begin
      ar_cyc[ar_total % 256] <= cyc;
      ar_total      <= ar_total + 1;
      m_axil_rvalid <= 1'b1;
      m_axil_rresp  <= rresp_cfg;
      m_axil_rdata  <= rd_val;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wdv,
                         input logic [3:0] wsv, input logic [31:0] mk,
                         output logic [31:0] rd, output logic [1:0] st,
                         output logic [15:0] pc, output int lat);
    int n;
    int t0;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    cmd_wdata = wdv; cmd_wstrb = wsv; cmd_mask = mk;
    @(posedge clk); #1;
    t0 = cyc;
    cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata; st = rsp_status; pc = rsp_polls; lat = cyc - t0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic [31:0] r_dat;
  logic [1:0]  r_st;
  logic [15:0] r_pc;
  int          r_lat;
  int          s_aw, s_w, s_b, s_ar, min_gap, rsp_seen, n;

  initial begin
    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valids", 32'({rsp_valid, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                           m_axil_arvalid, m_axil_rready}), 32'd0);
    chk("rst_rsp_dat", rsp_rdata, 32'd0);
    chk("rst_rsp_meta", 32'({rsp_status, rsp_polls}), 32'd0);
    chk("rst_prot", 32'({m_axil_awprot, m_axil_arprot}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---- 1: zero-wait write then read back ----
    run_cmd(2'b00, 8'h00, 32'h0000_0040, 4'hF, 32'h0, r_dat, r_st, r_pc, r_lat);
    chk("wr_status", 32'(r_st), 32'd0);
    chk("wr_polls", 32'(r_pc), 32'd0);
    chk("wr_rdata", r_dat, 32'd0);
    chk("wr_latency", 32'(r_lat), 32'd2);
    chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
    run_cmd(2'b01, 8'h00, 32'h0, 4'h0, 32'h0, r_dat, r_st, r_pc, r_lat);
    chk("rd_rdata", r_dat, 32'h0000_0040);
    chk("rd_status", 32'(r_st), 32'd0);
    chk("rd_polls", 32'(r_pc), 32'd1);
    chk("rd_latency", 32'(r_lat), 32'd2);

    // ---- 2: AW delayed 3 cycles, partial strobes ----
    aw_dly = 3; s_aw = aw_hi; s_w = w_hi; s_b = b_total;
    run_cmd(2'b00, 8'h04, 32'h1234_5678, 4'h3, 32'h0, r_dat, r_st, r_pc, r_lat);
    aw_dly = 0;
    chk("slow_aw_status", 32'(r_st), 32'd0);
    chk("slow_aw_awvalid_cycles", 32'(aw_hi - s_aw), 32'd4);
    chk("slow_aw_wvalid_cycles", 32'(w_hi - s_w), 32'd1);
    chk("slow_aw_b_count", 32'(b_total - s_b), 32'd1);
    run_cmd(2'b11, 8'h04, 32'h0, 4'h0, 32'h0, r_dat, r_st, r_pc, r_lat);
    chk("strobe_readback", r_dat, 32'h0000_5678);

    // ---- 3: poll matches on 6th read (the last one allowed) ----
    poll_base = ar_total; poll_zeros = 5; s_ar = ar_total;
    run_cmd(2'b10, POLL_ADDR, 32'h1, 4'h0, 32'h1, r_dat, r_st, r_pc, r_lat);
    chk("poll_status", 32'(r_st), 32'd0);
    chk("poll_polls", 32'(r_pc), 32'd6);
    chk("poll_rdata", r_dat, 32'h1);
    chk("poll_ar_count", 32'(ar_total - s_ar), 32'd6);
    min_gap = 1000;
    for (int i = 1; i < 6; i++)
      if (ar_cyc[(s_ar + i) % 256] - ar_cyc[(s_ar + i - 1) % 256] < min_gap)
        min_gap = ar_cyc[(s_ar + i) % 256] - ar_cyc[(s_ar + i - 1) % 256];
    chk("poll_ar_gap_ge5", 32'(min_gap >= 5), 32'd1);

    // ---- 4: poll never matches -> exhausted after POLL_LIMIT reads ----
    poll_base = ar_total; poll_zeros = 1000; s_ar = ar_total;
    run_cmd(2'b10, POLL_ADDR, 32'h1, 4'h0, 32'h1, r_dat, r_st, r_pc, r_lat);
    chk("pollx_status", 32'(r_st), 32'd2);
    chk("pollx_polls", 32'(r_pc), 32'd6);
    chk("pollx_rdata", r_dat, 32'h0000_0600);
    chk("pollx_ar_count", 32'(ar_total - s_ar), 32'd6);

    // masked compare: 0x40 & 0xF0 equals 0x4F & 0xF0 on the first read
    run_cmd(2'b10, 8'h00, 32'h0000_004F, 4'h0, 32'h0000_00F0, r_dat, r_st, r_pc, r_lat);
    chk("mask_poll_status", 32'(r_st), 32'd0);
    chk("mask_poll_polls", 32'(r_pc), 32'd1);

    // ---- 5: bus errors ----
    rresp_cfg = 2'b10;
    run_cmd(2'b01, 8'h08, 32'h0, 4'h0, 32'h0, r_dat, r_st, r_pc, r_lat);
    chk("rd_err_status", 32'(r_st), 32'd1);
    poll_base = ar_total; poll_zeros = 1000; s_ar = ar_total;
    run_cmd(2'b10, POLL_ADDR, 32'h1, 4'h0, 32'h1, r_dat, r_st, r_pc, r_lat);
    repeat (12) @(posedge clk);
    #1;
    chk("poll_err_status", 32'(r_st), 32'd1);
    chk("poll_err_polls", 32'(r_pc), 32'd1);
    chk("poll_err_ar_count", 32'(ar_total - s_ar), 32'd1);
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b10;
    run_cmd(2'b00, 8'h0C, 32'hDEAD_BEEF, 4'hF, 32'h0, r_dat, r_st, r_pc, r_lat);
    chk("wr_err_status", 32'(r_st), 32'd1);
    bresp_cfg = 2'b00;

    // ---- 6: reset while AR is stalled ----
    ar_block = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 8'h0C;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_arvalid_held", 32'(m_axil_arvalid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_arvalid", 32'(m_axil_arvalid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst = 1'b0; ar_block = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rsp_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || m_axil_arvalid) rsp_seen++;
    end
    chk("after_rst_quiet", 32'(rsp_seen), 32'd0);
    run_cmd(2'b01, 8'h00, 32'h0, 4'h0, 32'h0, r_dat, r_st, r_pc, r_lat);
    chk("recover_rdata", r_dat, 32'h0000_0040);

    chk("no_ar_aw_overlap", 32'(overlap_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
